dot_accumulator_16: RTL and testbench
=====================================

# dot_accumulator_16

Signed 16-bit product stream accumulator that sits directly downstream of the pipelined 16-bit multiplier in the MHA datapath. Consumes one Q2.13 product per `I_VLD` pulse, sums `P_LEN` products in a widened accumulator, then emits one 16-bit Q2.13 dot-product result with an overflow flag. Used to form Q·K and attention·V inner products.

## Interface
- `P_LEN`, default 16: products per dot product; must be ≥2.
- `P_GUARD`, default `$clog2(P_LEN)`: accumulator guard bits; accumulator width `AW = 16 + P_GUARD`.
- `I_CLK` input 1: clock; all state changes on the rising edge.
- `I_RST_N` input 1: reset, asynchronous, active-low.
- `I_VLD` input 1: product valid, driven by the multiplier's `O_VLD`.
- `I_PRODUCT` input 16: signed two's-complement Q2.13 product.
- `I_CLR` input 1: synchronous abort; discards the partial sum.
- `O_VLD` output 1: result valid, one-cycle pulse.
- `O_SUM` output 16: signed Q2.13 dot product.
- `O_OVF` output 1: the accumulated value fell outside the 16-bit range; valid with `O_VLD`.
- `O_ACC_BUSY` output 1: a partial sum is in progress (count ≠ 0).

## Operation
- States: `IDLE` (count = 0, acc = 0) and `ACC` (1 ≤ count ≤ P_LEN-1).
- `IDLE` with `I_VLD`: acc ← sign-extended `I_PRODUCT`, count ← 1, go to `ACC`.
- `ACC` with `I_VLD` and count < P_LEN-1: acc ← acc + sext(`I_PRODUCT`), count ← count+1.
- `ACC` with `I_VLD` and count = P_LEN-1 (last term):
  - Register final = acc + sext(`I_PRODUCT`) into the output stage.
  - Clear acc and count, return to `IDLE`.
- No `I_VLD`: hold state. Gaps of any length between products are legal.
- Range check on final: out of range when final > 32767 or final < -32768.
- `O_OVF` = out of range. `O_SUM` per Configuration.
- `I_CLR` has priority over `I_VLD` in the same cycle: acc, count → 0, state → `IDLE`, and that cycle's product is dropped. No `O_VLD` is produced for the aborted sum.
- An `I_CLR` asserted in the same cycle as a last-term completion still suppresses that `O_VLD`.
- Internal addition never wraps: with P_LEN terms of ±32768, the AW-bit accumulator is exact.

## Timing
- Reset values: `O_VLD`=0, `O_SUM`=0x0000, `O_OVF`=0, `O_ACC_BUSY`=0. Internal acc and count are also 0.
- Latency: `O_VLD`/`O_SUM`/`O_OVF` assert in the cycle after the edge that captures the last product.
- Outputs are registered. `O_VLD` is high for exactly one cycle. `O_SUM` and `O_OVF` return to 0 when `O_VLD` falls.
- Back-to-back operation: a product arriving in the cycle `O_VLD` is high is term 1 of the next dot product, with zero bubble. Sustained throughput is one product per cycle.
- `O_ACC_BUSY` is registered and high from the cycle after term 1 until the cycle after the last term or `I_CLR`.
- No back-pressure: every `I_VLD` is accepted.
- Reset mid-sum: everything clears asynchronously and the partial sum is lost.

## Configuration
- `ACC_SAT_EN` defined:
  - Out-of-range final saturates: `O_SUM` = 0x7FFF when positive, 0x8000 when negative.
  - In-range values pass unchanged.
- `ACC_SAT_EN` undefined:
  - `O_SUM` = final[15:0] (wrap-around).
  - `O_OVF` is still computed and reported identically.

## Structure
- Shared package `mha_pkg`:
  - `DATA_W` = 16, `FRAC_W` = 13.
  - Q2.13 constants `Q_MAX` = 16'h7FFF, `Q_MIN` = 16'h8000, `Q_ONE` = 16'h2000.
  - State enum `acc_state_t` {`ACC_IDLE`, `ACC_RUN`}.
- One sub-module: `sat_narrow`, a combinational AW→16 range check plus saturate/wrap selection. It owns the `ACC_SAT_EN` logic and produces the 16-bit value and the overflow bit.

## Test plan
- P_LEN=4, products 0x2000, 0xE000, 0x1000, 0x0800 on consecutive cycles -> one `O_VLD` one cycle after the 4th product, `O_SUM`=0x1800, `O_OVF`=0.
- P_LEN=4, four × 0x2000 -> `O_OVF`=1; `O_SUM`=0x7FFF with `ACC_SAT_EN`, 0x8000 without.
- P_LEN=4, four × 0x8000 -> `O_OVF`=1; `O_SUM`=0x8000 with `ACC_SAT_EN`, 0x0000 without.
- P_LEN=4, two products, then `I_CLR` together with a third `I_VLD`, then four × 0x0400 -> exactly one `O_VLD`, `O_SUM`=0x1000. `O_ACC_BUSY` drops the cycle after `I_CLR`.
- P_LEN=4, eight consecutive 0x0100 products with no gaps -> two `O_VLD` pulses four cycles apart, each with `O_SUM`=0x0400. The 5th product is accepted in the cycle the first `O_VLD` is high.
- Assert `I_RST_N`=0 after 2 of 4 products, release, then feed 4 × 0x0200 -> all outputs 0 during reset, then a single `O_SUM`=0x0800.

Source files
------------

// File: rtl/mha_pkg.sv
// Shared MHA datapath definitions: Q2.13 word format, its constants and the
// dot-product accumulator state encoding.
package mha_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 13;

    localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;
    localparam logic [DATA_W-1:0] Q_ONE = 16'h2000;

    typedef enum logic [0:0] {
        ACC_IDLE = 1'b0,
        ACC_RUN  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/dot_accumulator_16_if.sv
// Product stream in / dot-product result out. The master side feeds
// products; the slave side is the accumulator.
interface dot_accumulator_16_if;
    import mha_pkg::*;

    logic              I_VLD;
    logic [DATA_W-1:0] I_PRODUCT;
    logic              I_CLR;
    logic              O_VLD;
    logic [DATA_W-1:0] O_SUM;
    logic              O_OVF;
    logic              O_ACC_BUSY;

    modport master (
        output I_VLD,
        output I_PRODUCT,
        output I_CLR,
        input  O_VLD,
        input  O_SUM,
        input  O_OVF,
        input  O_ACC_BUSY
    );

    modport slave (
        input  I_VLD,
        input  I_PRODUCT,
        input  I_CLR,
        output O_VLD,
        output O_SUM,
        output O_OVF,
        output O_ACC_BUSY
    );

endinterface

// File: rtl/dot_accumulator_16_sat_narrow.sv
// Combinational AW -> 16-bit narrowing with range check.
// ACC_SAT_EN defined: out-of-range values clamp to Q_MAX/Q_MIN; otherwise wrap.
module sat_narrow
    import mha_pkg::*;
#(
    parameter int AW = 20
) (
    input  logic [AW-1:0]     acc_value,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

    // The value fits in 16 bits exactly when every bit from the 16-bit sign
    // position upward carries the same value.
    logic [AW-DATA_W:0] top_bits;
    logic               in_range;

    assign top_bits = acc_value[AW-1:DATA_W-1];
    assign in_range = (&top_bits) | ~(|top_bits);
    assign ovf      = ~in_range;

`ifdef ACC_SAT_EN
    always_comb begin
        result = acc_value[DATA_W-1:0];
        if (!in_range) begin
            result = acc_value[AW-1] ? Q_MIN : Q_MAX;
        end
    end
`else
    assign result = acc_value[DATA_W-1:0];
`endif

endmodule

// File: rtl/dot_accumulator_16.sv
// Accumulates P_LEN signed Q2.13 products into one 16-bit dot-product result.
// Optional ACC_SAT_EN selects saturating (instead of wrapping) narrowing.
module dot_accumulator_16
    import mha_pkg::*;
#(
    parameter int P_LEN   = 16,
    parameter int P_GUARD = $clog2(P_LEN)
) (
    input logic                 I_CLK,
    input logic                 I_RST_N,
    dot_accumulator_16_if.slave bus
);

    localparam int AW = DATA_W + P_GUARD;
    localparam int CW = $clog2(P_LEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(P_LEN - 1);

    acc_state_t        state_reg;
    logic [AW-1:0]     acc_reg;
    logic [CW-1:0]     count_reg;
    logic              vld_reg;
    logic [DATA_W-1:0] sum_reg;
    logic              ovf_reg;
    logic              busy_reg;

    logic [AW-1:0]     product_ext;
    logic [AW-1:0]     acc_next;
    logic [DATA_W-1:0] narrow_sum;
    logic              narrow_ovf;
    logic              last_term;

    assign product_ext[DATA_W-1:0] = bus.I_PRODUCT;
    for (genvar gi = DATA_W; gi < AW; gi++) begin : g_sext
        assign product_ext[gi] = bus.I_PRODUCT[DATA_W-1];
    end

    assign acc_next  = acc_reg + product_ext;
    assign last_term = (state_reg == ACC_RUN) && (count_reg == LAST_CNT);

    sat_narrow #(
        .AW (AW)
    ) u_sat_narrow (
        .acc_value (acc_next),
        .result    (narrow_sum),
        .ovf       (narrow_ovf)
    );

    // Result registers default to zero so O_SUM/O_OVF are only nonzero
    // during the single O_VLD cycle.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_reg <= ACC_IDLE;
            acc_reg   <= '0;
            count_reg <= '0;
            vld_reg   <= 1'b0;
            sum_reg   <= '0;
            ovf_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            vld_reg <= 1'b0;
            sum_reg <= '0;
            ovf_reg <= 1'b0;
            if (bus.I_CLR) begin
                state_reg <= ACC_IDLE;
                acc_reg   <= '0;
                count_reg <= '0;
                busy_reg  <= 1'b0;
            end else if (bus.I_VLD) begin
                case (state_reg)
                    ACC_IDLE: begin
                        acc_reg   <= product_ext;
                        count_reg <= CW'(1);
                        state_reg <= ACC_RUN;
                        busy_reg  <= 1'b1;
                    end
                    ACC_RUN: begin
                        if (last_term) begin
                            vld_reg   <= 1'b1;
                            sum_reg   <= narrow_sum;
                            ovf_reg   <= narrow_ovf;
                            acc_reg   <= '0;
                            count_reg <= '0;
                            state_reg <= ACC_IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            acc_reg   <= acc_next;
                            count_reg <= count_reg + CW'(1);
                        end
                    end
                    default: begin
                        state_reg <= ACC_IDLE;
                        acc_reg   <= '0;
                        count_reg <= '0;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.O_VLD      = vld_reg;
    assign bus.O_SUM      = sum_reg;
    assign bus.O_OVF      = ovf_reg;
    assign bus.O_ACC_BUSY = busy_reg;

endmodule

// File: tb/tb_dot_accumulator_16.sv
// Directed bench for dot_accumulator_16 with P_LEN=4: vector table plus
// hand-written reset sequences.
module tb_dot_accumulator_16;
    import mha_pkg::*;

    typedef struct {
        logic        vld;
        logic        clr;
        logic [15:0] prod;
        logic        exp_vld;
        logic [15:0] exp_sum;
        logic        exp_ovf;
        logic        exp_busy;
    } vec_t;

`ifdef ACC_SAT_EN
    localparam logic [15:0] EXP_POS_OVF = 16'h7FFF;
    localparam logic [15:0] EXP_NEG_OVF = 16'h8000;
`else
    localparam logic [15:0] EXP_POS_OVF = 16'h8000;
    localparam logic [15:0] EXP_NEG_OVF = 16'h0000;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    dot_accumulator_16_if bus();

    dot_accumulator_16 #(
        .P_LEN (4)
    ) dut (
        .I_CLK   (clk),
        .I_RST_N (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    vec_t vecs [0:63];
    int   n_vecs = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic add(input logic v, input logic c, input logic [15:0] p,
                       input logic ev, input logic [15:0] es, input logic eo,
                       input logic eb);
        vecs[n_vecs].vld      = v;
        vecs[n_vecs].clr      = c;
        vecs[n_vecs].prod     = p;
        vecs[n_vecs].exp_vld  = ev;
        vecs[n_vecs].exp_sum  = es;
        vecs[n_vecs].exp_ovf  = eo;
        vecs[n_vecs].exp_busy = eb;
        n_vecs++;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [15:0] es,
                              input logic eo, input logic eb);
        check({tag, "_vld"},  16'(bus.O_VLD), 16'(ev));
        check({tag, "_sum"},  bus.O_SUM, es);
        check({tag, "_ovf"},  16'(bus.O_OVF), 16'(eo));
        check({tag, "_busy"}, 16'(bus.O_ACC_BUSY), 16'(eb));
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read back
    // 1 time unit after the edge that consumed them.
    task automatic apply(input logic v, input logic c, input logic [15:0] p);
        bus.I_VLD     = v;
        bus.I_CLR     = c;
        bus.I_PRODUCT = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.I_VLD = 1'b0;
        bus.I_CLR = 1'b0;
        bus.I_PRODUCT = '0;

        // 0.75 from 1.0 - 1.0 + 0.5 + 0.25
        add(1, 0, Q_ONE,   0, 16'h0000, 0, 1);
        add(1, 0, 16'hE000, 0, 16'h0000, 0, 1);
        add(1, 0, 16'h1000, 0, 16'h0000, 0, 1);
        add(1, 0, 16'h0800, 1, 16'h1800, 0, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 0, 0);
        // positive overflow: 4 * 1.0
        add(1, 0, Q_ONE, 0, 16'h0000, 0, 1);
        add(1, 0, Q_ONE, 0, 16'h0000, 0, 1);
        add(1, 0, Q_ONE, 0, 16'h0000, 0, 1);
        add(1, 0, Q_ONE, 1, EXP_POS_OVF, 1, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 0, 0);
        // negative overflow: 4 * -4.0
        add(1, 0, 16'h8000, 0, 16'h0000, 0, 1);
        add(1, 0, 16'h8000, 0, 16'h0000, 0, 1);
        add(1, 0, 16'h8000, 0, 16'h0000, 0, 1);
        add(1, 0, 16'h8000, 1, EXP_NEG_OVF, 1, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 0, 0);
        // abort with a simultaneous product, then a clean sum
        add(1, 0, 16'h1000, 0, 16'h0000, 0, 1);
        add(1, 0, 16'h1000, 0, 16'h0000, 0, 1);
        add(1, 1, 16'h7000, 0, 16'h0000, 0, 0);
        add(1, 0, 16'h0400, 0, 16'h0000, 0, 1);
        add(1, 0, 16'h0400, 0, 16'h0000, 0, 1);
        add(1, 0, 16'h0400, 0, 16'h0000, 0, 1);
        add(1, 0, 16'h0400, 1, 16'h1000, 0, 0);
        // back-to-back: term 5 arrives while O_VLD is high
        add(1, 0, 16'h0100, 0, 16'h0000, 0, 1);
        add(1, 0, 16'h0100, 0, 16'h0000, 0, 1);
        add(1, 0, 16'h0100, 0, 16'h0000, 0, 1);
        add(1, 0, 16'h0100, 1, 16'h0400, 0, 0);
        add(1, 0, 16'h0100, 0, 16'h0000, 0, 1);
        add(1, 0, 16'h0100, 0, 16'h0000, 0, 1);
        add(1, 0, 16'h0100, 0, 16'h0000, 0, 1);
        add(1, 0, 16'h0100, 1, 16'h0400, 0, 0);
        // gaps between terms hold state
        add(1, 0, 16'h0010, 0, 16'h0000, 0, 1);
        add(0, 0, 16'h0000, 0, 16'h0000, 0, 1);
        add(0, 0, 16'h0000, 0, 16'h0000, 0, 1);
        add(1, 0, 16'hFFF0, 0, 16'h0000, 0, 1);
        add(1, 0, 16'h0020, 0, 16'h0000, 0, 1);
        add(0, 0, 16'h0000, 0, 16'h0000, 0, 1);
        add(1, 0, 16'h0003, 1, 16'h0023, 0, 0);
        // clear on the last term suppresses the result
        add(1, 0, 16'h0100, 0, 16'h0000, 0, 1);
        add(1, 0, 16'h0100, 0, 16'h0000, 0, 1);
        add(1, 0, 16'h0100, 0, 16'h0000, 0, 1);
        add(1, 1, 16'h0100, 0, 16'h0000, 0, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 0, 0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 0, 16'h0000, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < n_vecs; i++) begin
            apply(vecs[i].vld, vecs[i].clr, vecs[i].prod);
            $display("vec %0d: vld=%0b clr=%0b prod=%04h -> O_VLD=%0b O_SUM=%04h O_OVF=%0b BUSY=%0b",
                     i, vecs[i].vld, vecs[i].clr, vecs[i].prod,
                     bus.O_VLD, bus.O_SUM, bus.O_OVF, bus.O_ACC_BUSY);
            check_outs($sformatf("row%0d", i), vecs[i].exp_vld, vecs[i].exp_sum,
                       vecs[i].exp_ovf, vecs[i].exp_busy);
        end

        // reset in the middle of a sum loses the partial
        apply(1, 0, 16'h0200);
        apply(1, 0, 16'h0200);
        check_outs("pre_rst", 0, 16'h0000, 0, 1);
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 0, 16'h0000, 0, 0);
        bus.I_VLD = 1'b1;
        bus.I_PRODUCT = 16'h0200;
        @(posedge clk);
        #1;
        check_outs("held_rst", 0, 16'h0000, 0, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            apply(1, 0, 16'h0200);
            $display("post-reset term %0d: O_VLD=%0b O_SUM=%04h BUSY=%0b",
                     k, bus.O_VLD, bus.O_SUM, bus.O_ACC_BUSY);
            if (k < 3)
                check_outs($sformatf("post_rst%0d", k), 0, 16'h0000, 0, 1);
            else
                check_outs("post_rst_last", 1, 16'h0800, 0, 0);
        end
        apply(0, 0, 16'h0000);
        check_outs("post_rst_idle", 0, 16'h0000, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
